// File: rtl/audio_fifo_rd_sched.sv
// Read-side scheduler for the dual-clock stereo audio FIFO (read-clock domain).
// Turns the sample-rate strobe into spaced single-cycle FIFO pops, holds the
// popped L/R pair for the serializer, and handles prefill and underrun recovery.
module audio_fifo_rd_sched #(
  parameter int unsigned DataWidth      = 24,
  parameter int unsigned SettleCycles   = 2,
  parameter int unsigned CntWidth       = 16,
  parameter bit          MuteOnUnderrun = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 sample_tick_i,
  input  logic                 clr_cnt_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_almost_empty_i,
  input  logic [DataWidth-1:0] fifo_L_i,
  input  logic [DataWidth-1:0] fifo_R_i,
  output logic                 fifo_rd_en_o,
  output logic [DataWidth-1:0] L_o,
  output logic [DataWidth-1:0] R_o,
  output logic                 valid_o,
  output logic                 underrun_o,
  output logic [CntWidth-1:0]  underrun_cnt_o,
  output logic [1:0]           state_o
);

  // Settle counter must hold SettleCycles; keep at least one bit when it is 0.
  localparam int unsigned SettleWidth = (SettleCycles < 1) ? 1 : $clog2(SettleCycles + 1);
  localparam logic [SettleWidth-1:0] SettleLoad = SettleWidth'(SettleCycles);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPrefill = 2'd1,
    StRun     = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   pending_q;
  logic [SettleWidth-1:0] settle_q;

  logic settled;
  logic svc_req;
  logic do_service;
  logic do_read;
  logic do_underrun;
  logic do_prefill_fill;
  logic do_fill;

  // Service decode: a tick (live or held) in RUN once the previous read has settled.
  assign settled         = (settle_q == '0);
  assign svc_req         = sample_tick_i | pending_q;
  assign do_service      = en_i & (state_q == StRun) & svc_req & settled;
  assign do_read         = do_service & ~fifo_empty_i;
  assign do_underrun     = do_service & fifo_empty_i;
  assign do_prefill_fill = en_i & (state_q == StPrefill) & sample_tick_i;
  assign do_fill         = do_underrun | do_prefill_fill;

  assign state_o = state_q;

  // Control FSM with settle spacing, single-slot pending tick and strobe outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pending_q    <= 1'b0;
      settle_q     <= '0;
      fifo_rd_en_o <= 1'b0;
      valid_o      <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      fifo_rd_en_o <= 1'b0;
      valid_o      <= 1'b0;
      underrun_o   <= 1'b0;

      if (!en_i) begin
        // Disable wins everywhere: drop back to IDLE and forget spacing state.
        state_q   <= StIdle;
        pending_q <= 1'b0;
        settle_q  <= '0;
      end else begin
        case (state_q)
          StIdle:    state_q <= StPrefill;
          StPrefill: if (!fifo_almost_empty_i) state_q <= StRun;
          StRun:     if (do_underrun) state_q <= StPrefill;
          default:   state_q <= StIdle;
        endcase

        // A read restarts the settle window; otherwise it drains to zero.
        if (do_read) begin
          settle_q <= SettleLoad;
        end else if (!settled) begin
          settle_q <= settle_q - SettleWidth'(1);
        end

        // A tick that cannot be served yet is remembered once; extras are dropped.
        if (do_service) begin
          pending_q <= 1'b0;
        end else if ((state_q == StRun) && sample_tick_i) begin
          pending_q <= 1'b1;
        end

        fifo_rd_en_o <= do_read;
        valid_o      <= do_read | do_fill;
        underrun_o   <= do_underrun;
      end
    end
  end

  // Output sample hold: capture FIFO data on reads, mute or repeat on fills.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      L_o <= '0;
      R_o <= '0;
    end else if (do_read) begin
      L_o <= fifo_L_i;
      R_o <= fifo_R_i;
    end else if (do_fill && MuteOnUnderrun) begin
      L_o <= '0;
      R_o <= '0;
    end
  end

  // Saturating underrun counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      underrun_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      underrun_cnt_o <= '0;
    end else if (do_underrun && (underrun_cnt_o != '1)) begin
      underrun_cnt_o <= underrun_cnt_o + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_audio_fifo_rd_sched.sv
// Bench for audio_fifo_rd_sched: two instances (muting/16-bit counter and
// repeating/2-bit counter) share stimulus; a cycle-level behavioural model
// based on read-edge distances tracks the expected outputs of both.
module tb_audio_fifo_rd_sched;

  localparam int unsigned DW     = 24;
  localparam int          SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst, en, tick, clr, empty, ae;
  logic [DW-1:0] fl, fr;

  logic          rd_a, valid_a, unr_a, rd_b, valid_b, unr_b;
  logic [DW-1:0] La, Ra, Lb, Rb;
  logic [15:0]   cnta;
  logic [1:0]    cntb;
  logic [1:0]    state_a, state_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  audio_fifo_rd_sched dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sample_tick_i(tick), .clr_cnt_i(clr),
    .fifo_empty_i(empty), .fifo_almost_empty_i(ae), .fifo_L_i(fl), .fifo_R_i(fr),
    .fifo_rd_en_o(rd_a), .L_o(La), .R_o(Ra), .valid_o(valid_a), .underrun_o(unr_a),
    .underrun_cnt_o(cnta), .state_o(state_a)
  );

  audio_fifo_rd_sched #(
    .DataWidth(DW), .SettleCycles(SETTLE), .CntWidth(2), .MuteOnUnderrun(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sample_tick_i(tick), .clr_cnt_i(clr),
    .fifo_empty_i(empty), .fifo_almost_empty_i(ae), .fifo_L_i(fl), .fifo_R_i(fr),
    .fifo_rd_en_o(rd_b), .L_o(Lb), .R_o(Rb), .valid_o(valid_b), .underrun_o(unr_b),
    .underrun_cnt_o(cntb), .state_o(state_b)
  );

  // Reference model: a read is allowed only if more than SETTLE edges separate
  // it from the previous read; one waiting tick is remembered.
  int          m_state, m_cnta, m_cntb, edge_n, last_rd_edge;
  bit          m_rd, m_valid, m_unr, held, want, ready;
  logic [DW-1:0] m_La, m_Ra, m_Lb, m_Rb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_rd = 0; m_valid = 0; m_unr = 0;
      m_La = '0; m_Ra = '0; m_Lb = '0; m_Rb = '0;
      m_cnta = 0; m_cntb = 0; held = 0; edge_n = 0; last_rd_edge = -1000;
    end else begin
      edge_n = edge_n + 1;
      m_rd = 0; m_valid = 0; m_unr = 0;
      if (clr) begin m_cnta = 0; m_cntb = 0; end
      if (!en) begin
        m_state = 0; held = 0; last_rd_edge = -1000;
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        if (tick) begin m_valid = 1; m_La = '0; m_Ra = '0; end
        if (!ae) m_state = 2;
      end else begin
        want  = tick || held;
        ready = (edge_n - last_rd_edge) > SETTLE;
        if (want && ready) begin
          held = 0;
          if (empty) begin
            m_valid = 1; m_unr = 1; m_La = '0; m_Ra = '0;
            if (!clr) begin
              if (m_cnta < 65535) m_cnta = m_cnta + 1;
              if (m_cntb < 3) m_cntb = m_cntb + 1;
            end
            m_state = 1;
          end else begin
            m_rd = 1; m_valid = 1;
            m_La = fl; m_Ra = fr; m_Lb = fl; m_Rb = fr;
            last_rd_edge = edge_n;
          end
        end else if (tick) begin
          held = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; tick = 0; clr = 0; empty = 1; ae = 1; fl = '0; fr = '0;
    step(); step();
    checks++;
    if ({state_a, rd_a, valid_a, unr_a, state_b, rd_b, valid_b, unr_b} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got a=%0d/%b%b%b b=%0d/%b%b%b expected all zero",
               state_a, rd_a, valid_a, unr_a, state_b, rd_b, valid_b, unr_b);
    end
    checks++;
    if ({La, Ra, Lb, Rb} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected zeros", La, Ra, Lb, Rb);
    end
    checks++;
    if ({cnta, cntb} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d expected 0 0", cnta, cntb);
    end
    rst = 0;
    step();
    checks++;
    if (state_a !== 2'd0) begin
      errors++;
      $display("FAIL idle_hold: got state %0d expected 0", state_a);
    end
  endtask

  task automatic test_prefill();
    bit t;
    en = 1; fl = 24'h5A5A5A; fr = 24'hA5A5A5; empty = 0;
    step();
    checks++;
    if (state_a !== 2'd1) begin
      errors++;
      $display("FAIL idle_to_prefill: got state %0d expected 1", state_a);
    end
    for (int i = 0; i < 10; i++) begin
      t = (i % 3 == 0);
      tick = t;
      step();
      checks++;
      if ({state_a, rd_a, valid_a, La, Ra, rd_b, Lb} !== {2'd1, 1'b0, t, 24'd0, 24'd0, 1'b0, 24'd0}) begin
        errors++;
        $display("FAIL prefill_cycle %0d: got st=%0d rd=%b v=%b L=%h R=%h rdb=%b Lb=%h expected st=1 rd=0 v=%b zeros",
                 i, state_a, rd_a, valid_a, La, Ra, rd_b, Lb, t);
      end
    end
    ae = 0; tick = 1;
    step();
    tick = 0;
    checks++;
    if ({state_a, rd_a, valid_a, La} !== {2'd2, 1'b0, 1'b1, 24'd0}) begin
      errors++;
      $display("FAIL prefill_exit_tick: got st=%0d rd=%b v=%b L=%h expected st=2 rd=0 v=1 L=0",
               state_a, rd_a, valid_a, La);
    end
  endtask

  task automatic test_single_read();
    empty = 0; fl = 24'h123456; fr = 24'hABCDEF; tick = 1;
    step();
    tick = 0;
    checks++;
    if ({rd_a, valid_a, La, Ra, rd_b, Lb, Rb} !== {1'b1, 1'b1, 24'h123456, 24'hABCDEF, 1'b1, 24'h123456, 24'hABCDEF}) begin
      errors++;
      $display("FAIL single_read: got rd=%b v=%b L=%h R=%h Lb=%h Rb=%h expected 1 1 123456 abcdef",
               rd_a, valid_a, La, Ra, Lb, Rb);
    end
    fl = 24'h0; fr = 24'h0;
    step();
    checks++;
    if ({rd_a, valid_a, La} !== {1'b0, 1'b0, 24'h123456}) begin
      errors++;
      $display("FAIL single_read_pulse: got rd=%b v=%b L=%h expected 0 0 123456", rd_a, valid_a, La);
    end
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd_mask = '0;
    logic [7:0] v_mask = '0;
    int n_rd = 0;
    for (int i = 0; i < 8; i++) begin
      tick = (i < 3);
      fl = 24'h100 + 24'(i); fr = 24'h200 + 24'(i);
      step();
      rd_mask[i] = rd_a;
      v_mask[i]  = valid_a;
      n_rd += int'(rd_a);
    end
    tick = 0;
    checks++;
    if (rd_mask !== 8'b0000_1001 || n_rd != 2) begin
      errors++;
      $display("FAIL b2b_rd: got mask %b count %0d expected 00001001 count 2", rd_mask, n_rd);
    end
    checks++;
    if (v_mask !== 8'b0000_1001) begin
      errors++;
      $display("FAIL b2b_valid: got mask %b expected 00001001", v_mask);
    end
    checks++;
    if ({La, Ra} !== {24'h103, 24'h203}) begin
      errors++;
      $display("FAIL b2b_data: got %h %h expected 000103 000203", La, Ra);
    end
  endtask

  task automatic test_underrun();
    fl = 24'h000111; fr = 24'h000222; empty = 0; tick = 1;
    step();
    tick = 0;
    checks++;
    if (Lb !== 24'h000111) begin
      errors++;
      $display("FAIL pre_underrun_read: got %h expected 000111", Lb);
    end
    step(); step(); step();
    empty = 1; tick = 1; fl = 24'hFFFFFF; fr = 24'hFFFFFF;
    step();
    tick = 0;
    checks++;
    if ({valid_a, rd_a, unr_a, state_a, valid_b, rd_b, unr_b, state_b} !==
        {1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL underrun_ctrl: got a v=%b rd=%b u=%b st=%0d b v=%b rd=%b u=%b st=%0d expected v=1 rd=0 u=1 st=1",
               valid_a, rd_a, unr_a, state_a, valid_b, rd_b, unr_b, state_b);
    end
    checks++;
    if ({Lb, Rb} !== {24'h000111, 24'h000222}) begin
      errors++;
      $display("FAIL underrun_repeat: got %h %h expected 000111 000222", Lb, Rb);
    end
    checks++;
    if ({La, Ra} !== 48'd0) begin
      errors++;
      $display("FAIL underrun_mute: got %h %h expected zeros", La, Ra);
    end
    checks++;
    if (cnta !== 16'd1 || cntb !== 2'd1) begin
      errors++;
      $display("FAIL underrun_cnt: got %0d %0d expected 1 1", cnta, cntb);
    end
    step();
    checks++;
    if ({state_a, unr_a} !== {2'd2, 1'b0}) begin
      errors++;
      $display("FAIL underrun_recover: got st=%0d u=%b expected st=2 u=0", state_a, unr_a);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 4; k++) begin
      empty = 1; tick = 1;
      step();
      tick = 0;
      step();
    end
    checks++;
    if (cnta !== 16'd5 || cntb !== 2'd3) begin
      errors++;
      $display("FAIL cnt_saturate: got %0d %0d expected 5 3", cnta, cntb);
    end
    tick = 1; clr = 1;
    step();
    tick = 0; clr = 0;
    checks++;
    if ({unr_a, cnta, cntb} !== {1'b1, 16'd0, 2'd0}) begin
      errors++;
      $display("FAIL clr_priority: got u=%b cnt=%0d/%0d expected u=1 cnt=0/0", unr_a, cnta, cntb);
    end
    step();
  endtask

  task automatic test_async_reset();
    empty = 0; fl = 24'hABCDE1; fr = 24'h1EDCBA; tick = 1;
    step();
    tick = 0;
    checks++;
    if ({rd_a, La} !== {1'b1, 24'hABCDE1}) begin
      errors++;
      $display("FAIL pre_reset_read: got rd=%b L=%h expected 1 abcde1", rd_a, La);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({state_a, rd_a, valid_a, unr_a, La, Ra, cnta, state_b, rd_b, valid_b, Lb, Rb} !== '0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d rd=%b v=%b u=%b L=%h R=%h cnt=%0d Lb=%h expected zeros",
               state_a, rd_a, valid_a, unr_a, La, Ra, cnta, Lb);
    end
    step();
    #2 rst = 0;
    #1;
    checks++;
    if (state_a !== 2'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got state %0d expected 0", state_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (state_a !== 2'd1) begin
      errors++;
      $display("FAIL reset_release_prefill: got state %0d expected 1", state_a);
    end
  endtask

  task automatic test_random();
    logic [68:0] got_a, exp_a;
    logic [54:0] got_b, exp_b;
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom_range(0, 99) >= 3);
      tick  = ($urandom_range(0, 99) < 40);
      empty = ($urandom_range(0, 99) < 15);
      ae    = ($urandom_range(0, 99) < 40);
      clr   = ($urandom_range(0, 99) < 2);
      fl    = DW'($urandom);
      fr    = DW'($urandom);
      step();
      got_a = {state_a, rd_a, valid_a, unr_a, La, Ra, cnta};
      exp_a = {2'(m_state), m_rd, m_valid, m_unr, m_La, m_Ra, 16'(m_cnta)};
      got_b = {state_b, rd_b, valid_b, unr_b, Lb, Rb, cntb};
      exp_b = {2'(m_state), m_rd, m_valid, m_unr, m_Lb, m_Rb, 2'(m_cntb)};
      checks++;
      if (got_a !== exp_a) begin
        errors++;
        $display("FAIL random_a cycle %0d: got %h expected %h", c, got_a, exp_a);
      end
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL random_b cycle %0d: got %h expected %h", c, got_b, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_single_read();
    test_back_to_back();
    test_underrun();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
